// File: rtl/i2c_cmd_sequencer_if.sv
// Bus bundle for i2c_cmd_sequencer: I2C byte input,
// multiplier handshake, result stream and status.
interface i2c_cmd_sequencer_if;
   logic        rx_done;
   logic [7:0]  rx_data;
   logic        mul_start;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic        mul_done;
   logic [15:0] mul_product;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_disp;
   logic [15:0] res_data;
   logic        overrun;
   logic [1:0]  frame_pos;

   modport master (
      input  rx_done, rx_data, mul_done, mul_product, res_ready,
      output mul_start, mul_a, mul_b, res_valid, res_disp, res_data,
      output overrun, frame_pos
   );

   modport slave (
      output rx_done, rx_data, mul_done, mul_product, res_ready,
      input  mul_start, mul_a, mul_b, res_valid, res_disp, res_data,
      input  overrun, frame_pos
   );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Frames I2C bytes into opcode/op1/op2 commands and executes them.
// Optional inter-byte and multiply timeout: define FRAME_TIMEOUT_EN.
module i2c_cmd_sequencer #(
   parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
   input logic                 clk,
   input logic                 rst,
   i2c_cmd_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, OP1, OP2, EXEC, WAIT_MUL, OUT
   } state_t;

   localparam logic [31:0] D_ADD = 32'h41444420;
   localparam logic [31:0] D_SUB = 32'h53554220;
   localparam logic [31:0] D_MUL = 32'h4D554C20;
   localparam logic [31:0] D_ERR = 32'h45525220;

   state_t      state, state_nx;
   logic        s1, s2, s3;
   logic        strobe;
   logic [1:0]  opc;
   logic [7:0]  op1, op2;
   logic [15:0] data_q;
   logic [31:0] disp_q;
   logic        ovr_q;
   logic        timeout;
   logic        mul_busy;

   // rx_done comes from another clock domain: 2-FF sync, then edge detect
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= bus.rx_done;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign strobe = s2 & ~s3;

`ifdef FRAME_TIMEOUT_EN
   logic [31:0] to_cnt;
   logic        to_run;

   assign to_run = (state == OP1) || (state == OP2) ||
                   (state == WAIT_MUL);

   // Idle-cycle counter; a byte restarts it while a frame is being built
   always_ff @(posedge clk) begin
      if (rst || !to_run || (strobe && state != WAIT_MUL))
         to_cnt <= 32'd0;
      else
         to_cnt <= to_cnt + 32'd1;
   end

   assign timeout = to_run && (to_cnt == TIMEOUT_CYC - 32'd1);
`else
   logic unused_timeout_cfg;

   // Parameter only matters when the timeout is compiled in
   assign unused_timeout_cfg = |TIMEOUT_CYC;
   assign timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:     if (strobe) state_nx = OP1;
         OP1: begin
            if (strobe)       state_nx = OP2;
            else if (timeout) state_nx = IDLE;
         end
         OP2: begin
            if (strobe)       state_nx = EXEC;
            else if (timeout) state_nx = IDLE;
         end
         EXEC:     state_nx = (opc == 2'b10) ? WAIT_MUL : OUT;
         WAIT_MUL: if (bus.mul_done || timeout) state_nx = OUT;
         OUT:      if (bus.res_ready) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   // Byte capture, overrun flag and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         opc    <= 2'b00;
         op1    <= 8'h00;
         op2    <= 8'h00;
         data_q <= 16'h0000;
         disp_q <= 32'h0;
         ovr_q  <= 1'b0;
      end else begin
         if (strobe) begin
            case (state)
               IDLE:    opc   <= bus.rx_data[1:0];
               OP1:     op1   <= bus.rx_data;
               OP2:     op2   <= bus.rx_data;
               default: ovr_q <= 1'b1;
            endcase
         end
         if (state == EXEC) begin
            unique case (opc)
               2'b00: begin
                  data_q <= {8'h00, op1} + {8'h00, op2};
                  disp_q <= D_ADD;
               end
               2'b01: begin
                  data_q <= {8'h00, op1} - {8'h00, op2};
                  disp_q <= D_SUB;
               end
               2'b10: disp_q <= D_MUL;
               default: begin
                  data_q <= 16'h0000;
                  disp_q <= D_ERR;
               end
            endcase
         end
         if (state == WAIT_MUL) begin
            if (bus.mul_done) begin
               data_q <= bus.mul_product;
            end else if (timeout) begin
               data_q <= 16'h0000;
               disp_q <= D_ERR;
            end
         end
      end
   end

   assign mul_busy = ((state == EXEC) && (opc == 2'b10)) ||
                     (state == WAIT_MUL);

   assign bus.mul_start = (state == EXEC) && (opc == 2'b10);
   assign bus.mul_a     = mul_busy ? op1 : 8'h00;
   assign bus.mul_b     = mul_busy ? op2 : 8'h00;
   assign bus.res_valid = (state == OUT);
   assign bus.res_data  = data_q;
   assign bus.res_disp  = disp_q;
   assign bus.overrun   = ovr_q;
   assign bus.frame_pos = (state == IDLE) ? 2'd0 :
                          (state == OP1)  ? 2'd1 :
                          (state == OP2)  ? 2'd2 : 2'd3;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Testbench for i2c_cmd_sequencer: directed frames plus random
// frames checked against a command-level reference model.
module tb_i2c_cmd_sequencer;

   typedef struct {
      logic [15:0] data;
      logic [31:0] disp;
      bit          is_mul;
      logic [7:0]  a;
      logic [7:0]  b;
   } exp_t;

   logic clk;
   logic rst;

   i2c_cmd_sequencer_if bus();

   i2c_cmd_sequencer #(.TIMEOUT_CYC(100)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_res = 0;
   int   n_mulstart = 0;
   int   mul_lat = 4;
   bit   mul_abort = 0;
   int   rdy_mode = 0;
   int   vcyc = 0;
   int   last_vcyc = 0;
   int   ms0 = 0;
   logic [15:0] last_data = 0;
   logic [31:0] last_disp = 0;
   logic [7:0]  ma, mb;
   bit          prev_stall = 0;
   logic [47:0] hold = 0;
   exp_t        exp_q[$];
   exp_t        e_to;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference: what a command must produce, from its bytes
   function automatic exp_t model(input logic [7:0] op,
                                  input logic [7:0] a,
                                  input logic [7:0] b);
      exp_t e;
      e.a = a;
      e.b = b;
      e.is_mul = 0;
      case (op[1:0])
         2'd0: begin
            e.data = 16'(int'(a) + int'(b));
            e.disp = "ADD ";
         end
         2'd1: begin
            e.data = 16'(int'(a) - int'(b));
            e.disp = "SUB ";
         end
         2'd2: begin
            e.data = 16'(int'(a) * int'(b));
            e.disp = "MUL ";
            e.is_mul = 1;
         end
         default: begin
            e.data = 16'h0000;
            e.disp = "ERR ";
         end
      endcase
      return e;
   endfunction

   // Result stream ready driver
   initial begin
      bus.res_ready = 0;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0)      bus.res_ready = 1;
         else if (rdy_mode == 2) bus.res_ready = 0;
         else                    bus.res_ready = 1'($urandom_range(0, 1));
      end
   end

   // External multiplier with programmable latency
   initial begin
      bus.mul_done = 0;
      bus.mul_product = 0;
      forever begin
         @(negedge clk);
         if (!rst && bus.mul_start) begin
            n_mulstart++;
            mul_abort = 0;
            ma = bus.mul_a;
            mb = bus.mul_b;
            if (exp_q.size() == 0) begin
               chk("mul_start_unexpected", 64'(bus.mul_start), 64'(0));
            end else begin
               chk("mul_start_op", 64'(exp_q[0].is_mul), 64'(1));
               chk("mul_a", 64'(ma), 64'(exp_q[0].a));
               chk("mul_b", 64'(mb), 64'(exp_q[0].b));
            end
            repeat (mul_lat) @(posedge clk);
            #1;
            bus.mul_done = 1;
            bus.mul_product = 16'(int'(ma) * int'(mb));
            @(negedge clk);
            if (!mul_abort)
               chk("mul_ab_hold", 64'({bus.mul_a, bus.mul_b}),
                   64'({ma, mb}));
            @(posedge clk);
            #1;
            bus.mul_done = 0;
         end
      end
   end

   // Compare process: every valid cycle against the model
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 0;
            vcyc = 0;
         end else if (bus.res_valid) begin
            vcyc++;
            if (exp_q.size() == 0) begin
               chk("res_valid_unexpected", 64'(bus.res_valid), 64'(0));
            end else begin
               chk("res_data", 64'(bus.res_data), 64'(exp_q[0].data));
               chk("res_disp", 64'(bus.res_disp), 64'(exp_q[0].disp));
            end
            if (prev_stall)
               chk("stall_hold", 64'({bus.res_disp, bus.res_data}),
                   64'(hold));
            if (bus.res_ready) begin
               if (exp_q.size() > 0) void'(exp_q.pop_front());
               n_res++;
               last_vcyc = vcyc;
               last_data = bus.res_data;
               last_disp = bus.res_disp;
               vcyc = 0;
               prev_stall = 0;
            end else begin
               prev_stall = 1;
               hold = {bus.res_disp, bus.res_data};
            end
         end else begin
            if (prev_stall)
               chk("valid_held", 64'(bus.res_valid), 64'(1));
            prev_stall = 0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit timed,
                            input int gap);
      @(posedge clk);
      #1;
      bus.rx_data = b;
      bus.rx_done = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (timed && i == 3) chk("lat_early", 64'(bus.res_valid), 64'(0));
         if (timed && i == 4) chk("lat_valid", 64'(bus.res_valid), 64'(1));
      end
      @(posedge clk);
      #1;
      bus.rx_done = 0;
      repeat (3 + gap) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [7:0] a,
                             input logic [7:0] b, input bit timed,
                             input int gap);
      exp_q.push_back(model(op, a, b));
      send_byte(op, 0, gap);
      send_byte(a, 0, gap);
      send_byte(b, timed, gap);
   endtask

   task automatic wait_result(input int target);
      for (int i = 0; i < 400 && n_res < target; i++) @(posedge clk);
      chk("result_count", 64'(n_res), 64'(target));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1;
      mul_abort = 1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1;
      bus.rx_done = 0;
      bus.rx_data = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ctl", 64'({bus.res_valid, bus.mul_start, bus.overrun,
                            bus.frame_pos}), 64'(0));
      chk("reset_data", 64'({bus.res_disp, bus.res_data}), 64'(0));
      chk("reset_mul", 64'({bus.mul_a, bus.mul_b}), 64'(0));
      @(posedge clk);
      #1;
      rst = 0;

      // pin the model itself
      e_to = model(8'h01, 8'h05, 8'h07);
      chk("model_sub", 64'(e_to.data), 64'(16'hFFFE));
      e_to = model(8'hFE, 8'hFF, 8'hFF);
      chk("model_mul", 64'(e_to.data), 64'(16'hFE01));

      // ADD with frame_pos tracking and latency check
      rdy_mode = 0;
      exp_q.push_back(model(8'h00, 8'h12, 8'h34));
      send_byte(8'h00, 0, 0);
      @(negedge clk);
      chk("frame_pos_1", 64'(bus.frame_pos), 64'(1));
      send_byte(8'h12, 0, 0);
      @(negedge clk);
      chk("frame_pos_2", 64'(bus.frame_pos), 64'(2));
      send_byte(8'h34, 1, 0);
      wait_result(1);
      chk("add_data", 64'(last_data), 64'(16'h0046));
      chk("add_disp", 64'(last_disp), 64'(32'h41444420));
      chk("add_one_valid", 64'(last_vcyc), 64'(1));

      send_frame(8'h01, 8'h05, 8'h07, 1, 0);
      wait_result(2);
      chk("sub_data", 64'(last_data), 64'(16'hFFFE));
      chk("sub_disp", 64'(last_disp), 64'(32'h53554220));

      mul_lat = 4;
      send_frame(8'h02, 8'hFF, 8'hFF, 0, 0);
      wait_result(3);
      chk("mul_data", 64'(last_data), 64'(16'hFE01));
      chk("mul_disp", 64'(last_disp), 64'(32'h4D554C20));
      chk("mul_operands", 64'({ma, mb}), 64'(16'hFFFF));

      ms0 = n_mulstart;
      send_frame(8'h03, 8'hAA, 8'hBB, 1, 0);
      wait_result(4);
      chk("err_disp", 64'(last_disp), 64'(32'h45525220));
      chk("err_data", 64'(last_data), 64'(0));
      chk("err_no_mul", 64'(n_mulstart), 64'(ms0));
      chk("overrun_clear", 64'(bus.overrun), 64'(0));

      // stall with an extra byte during the stall
      rdy_mode = 2;
      send_frame(8'h00, 8'h20, 8'h22, 0, 0);
      for (int i = 0; i < 50 && !bus.res_valid; i++) @(negedge clk);
      chk("stall_valid", 64'(bus.res_valid), 64'(1));
      send_byte(8'h55, 0, 0);
      repeat (3) @(posedge clk);
      rdy_mode = 0;
      wait_result(5);
      chk("stall_data", 64'(last_data), 64'(16'h0042));
      @(negedge clk);
      chk("overrun_set", 64'(bus.overrun), 64'(1));
      send_frame(8'h01, 8'h10, 8'h01, 0, 0);
      wait_result(6);
      chk("after_ovr_data", 64'(last_data), 64'(16'h000F));

      // reset mid-frame
      send_byte(8'h02, 0, 0);
      send_byte(8'h09, 0, 0);
      do_reset();
      @(negedge clk);
      chk("rst_frame_pos", 64'(bus.frame_pos), 64'(0));
      chk("rst_overrun", 64'(bus.overrun), 64'(0));
      send_frame(8'h00, 8'h01, 8'h01, 0, 0);
      wait_result(7);
      chk("rst_add_data", 64'(last_data), 64'(16'h0002));

      // reset while waiting on the multiplier; late mul_done ignored
      mul_lat = 20;
      ms0 = n_mulstart;
      send_frame(8'h02, 8'h03, 8'h04, 0, 0);
      for (int i = 0; i < 50 && n_mulstart == ms0; i++) @(posedge clk);
      chk("wm_started", 64'(n_mulstart), 64'(ms0 + 1));
      repeat (3) @(posedge clk);
      do_reset();
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("wm_rst_idle", 64'({bus.res_valid, bus.frame_pos}), 64'(0));
      chk("wm_rst_nores", 64'(n_res), 64'(7));

      // randomized frames
      rdy_mode = 1;
      for (int k = 0; k < 40; k++) begin
         mul_lat = $urandom_range(1, 8);
         send_frame(8'($urandom), 8'($urandom), 8'($urandom), 0,
                    $urandom_range(0, 6));
         wait_result(8 + k);
         repeat ($urandom_range(0, 5)) @(posedge clk);
      end
      rdy_mode = 0;
      chk("rand_overrun", 64'(bus.overrun), 64'(0));

`ifdef FRAME_TIMEOUT_EN
      send_byte(8'h00, 0, 0);
      repeat (150) @(posedge clk);
      @(negedge clk);
      chk("to_frame_pos", 64'(bus.frame_pos), 64'(0));
      chk("to_nores", 64'(n_res), 64'(47));
      send_frame(8'h00, 8'h02, 8'h03, 0, 0);
      wait_result(48);
      chk("to_next_data", 64'(last_data), 64'(16'h0005));
      mul_lat = 200;
      e_to = model(8'h02, 8'h07, 8'h08);
      e_to.data = 16'h0000;
      e_to.disp = "ERR ";
      exp_q.push_back(e_to);
      send_byte(8'h02, 0, 0);
      send_byte(8'h07, 0, 0);
      send_byte(8'h08, 0, 0);
      wait_result(49);
      mul_abort = 1;
      chk("to_mul_disp", 64'(last_disp), 64'(32'h45525220));
      repeat (220) @(posedge clk);
      @(negedge clk);
      chk("to_late_done", 64'({bus.res_valid, bus.frame_pos}), 64'(0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
